// File: rtl/riscv_exu_bru.sv
// Branch/jump resolution unit: resolve register, single-cycle redirect, result FIFO.
// Optional macro RISCV_BRU_MISALIGN_EN: misaligned taken targets retire as exceptions.
module riscv_exu_bru #(
  parameter int XLEN  = 32,
  parameter int SEQ_W = 64,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [7:0]       in_op,
  input  logic [XLEN-1:0]  in_addr,
  input  logic [XLEN-1:0]  in_addr_next,
  input  logic [XLEN-1:0]  in_immed,
  input  logic [4:0]       in_rd,
  input  logic [SEQ_W-1:0] in_seq,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             flush,
  output logic [XLEN-1:0]  flush_addr,
  output logic [SEQ_W-1:0] flush_seq,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_wen,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_wdata,
  output logic [SEQ_W-1:0] out_seq,
  output logic [XLEN-1:0]  out_pc_wdata,
  output logic             out_exc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic             exc;
    logic             wen;
    logic [4:0]       rd;
    logic [XLEN-1:0]  wdata;
    logic [SEQ_W-1:0] seq;
    logic [XLEN-1:0]  pc;
  } ent_t;

  logic             s1_vld_q, s1_vld_d;
  logic [7:0]       s1_op_q, s1_op_d;
  logic [XLEN-1:0]  s1_addr_q, s1_addr_d, s1_next_q, s1_next_d, s1_imm_q, s1_imm_d;
  logic [XLEN-1:0]  s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d;
  logic [4:0]       s1_rd_q, s1_rd_d;
  logic [SEQ_W-1:0] s1_seq_q, s1_seq_d;

  ent_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             legal, eq, lt, ltu, taken, is_jump, exc, mispred, accept, push, pop;
  logic [XLEN-1:0]  link, jalr_sum, tgt, npc;
  logic [CW-1:0]    occ;
  ent_t             ent, head;

  // Stage-1 resolve, purely combinational off the captured operands
  always_comb begin
    legal    = (s1_op_q != 8'd0) && ((s1_op_q & (s1_op_q - 8'd1)) == 8'd0);
    eq       = (s1_rs1_q == s1_rs2_q);
    lt       = ($signed(s1_rs1_q) < $signed(s1_rs2_q));
    ltu      = (s1_rs1_q < s1_rs2_q);
    taken    = legal && ((s1_op_q[0] && eq)  || (s1_op_q[1] && !eq) ||
                         (s1_op_q[2] && lt)  || (s1_op_q[3] && !lt) ||
                         (s1_op_q[4] && ltu) || (s1_op_q[5] && !ltu) ||
                         s1_op_q[6] || s1_op_q[7]);
    is_jump  = legal && (s1_op_q[6] || s1_op_q[7]);
    link     = s1_addr_q + XLEN'(4);
    jalr_sum = s1_rs1_q + s1_imm_q;
    tgt      = s1_op_q[7] ? {jalr_sum[XLEN-1:1], 1'b0} : (s1_addr_q + s1_imm_q);
    npc      = taken ? tgt : link;
`ifdef RISCV_BRU_MISALIGN_EN
    exc      = taken && (tgt[1:0] != 2'b00);
`else
    exc      = 1'b0;
`endif
    mispred  = legal && !exc && (npc != s1_next_q);

    ent       = '0;
    ent.exc   = exc;
    ent.wen   = is_jump && (s1_rd_q != 5'd0) && !exc;
    ent.rd    = s1_rd_q;
    ent.wdata = is_jump ? link : '0;
    ent.seq   = s1_seq_q;
    ent.pc    = npc;
  end

  // Credit check counts the stage-1 op as already occupying a FIFO slot
  always_comb begin
    occ        = cnt_q + CW'(s1_vld_q);
    flush      = !reset && s1_vld_q && mispred;
    flush_addr = flush ? npc : '0;
    flush_seq  = flush ? (s1_seq_q + SEQ_W'(1)) : '0;
    in_rdy     = !reset && !flush && (occ < CW'(DEPTH));
    accept     = in_vld && in_rdy;
    out_vld    = !reset && (cnt_q != '0);
    pop        = out_vld && out_rdy;
    push       = s1_vld_q && !reset;
    head       = mem_q[rd_ptr_q];

    out_wen      = out_vld ? head.wen   : 1'b0;
    out_rd       = out_vld ? head.rd    : 5'd0;
    out_wdata    = out_vld ? head.wdata : '0;
    out_seq      = out_vld ? head.seq   : '0;
    out_pc_wdata = out_vld ? head.pc    : '0;
    out_exc      = out_vld ? head.exc   : 1'b0;
  end

  always_comb begin
    s1_vld_d  = accept;
    s1_op_d   = s1_op_q;
    s1_addr_d = s1_addr_q;
    s1_next_d = s1_next_q;
    s1_imm_d  = s1_imm_q;
    s1_rs1_d  = s1_rs1_q;
    s1_rs2_d  = s1_rs2_q;
    s1_rd_d   = s1_rd_q;
    s1_seq_d  = s1_seq_q;
    if (accept) begin
      s1_op_d   = in_op;
      s1_addr_d = in_addr;
      s1_next_d = in_addr_next;
      s1_imm_d  = in_immed;
      s1_rs1_d  = rs1_data;
      s1_rs2_d  = rs2_data;
      s1_rd_d   = in_rd;
      s1_seq_d  = in_seq;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    if (reset) begin
      s1_vld_d = 1'b0;
      s1_op_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    s1_vld_q  <= s1_vld_d;
    s1_op_q   <= s1_op_d;
    s1_addr_q <= s1_addr_d;
    s1_next_q <= s1_next_d;
    s1_imm_q  <= s1_imm_d;
    s1_rs1_q  <= s1_rs1_d;
    s1_rs2_q  <= s1_rs2_d;
    s1_rd_q   <= s1_rd_d;
    s1_seq_q  <= s1_seq_d;
    wr_ptr_q  <= wr_ptr_d;
    rd_ptr_q  <= rd_ptr_d;
    cnt_q     <= cnt_d;
    if (push) mem_q[wr_ptr_q] <= ent;
  end

endmodule

// File: tb/tb_riscv_exu_bru.sv
// Randomized + directed bench for riscv_exu_bru against a queue-based reference model.
module tb_riscv_exu_bru;
  logic        clock = 1'b0, reset = 1'b1;
  logic        in_vld = 1'b0, in_rdy, out_rdy = 1'b1;
  logic [7:0]  in_op = '0;
  logic [31:0] in_addr = '0, in_addr_next = '0, in_immed = '0, rs1_data = '0, rs2_data = '0;
  logic [4:0]  in_rd = '0;
  logic [63:0] in_seq = '0;
  logic        flush, out_vld, out_wen, out_exc;
  logic [31:0] flush_addr, out_wdata, out_pc_wdata;
  logic [63:0] flush_seq, out_seq;
  logic [4:0]  out_rd;

  riscv_exu_bru #(.XLEN(32), .SEQ_W(64), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy), .in_op(in_op),
    .in_addr(in_addr), .in_addr_next(in_addr_next), .in_immed(in_immed), .in_rd(in_rd),
    .in_seq(in_seq), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .flush_addr(flush_addr), .flush_seq(flush_seq), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_wen(out_wen), .out_rd(out_rd), .out_wdata(out_wdata), .out_seq(out_seq),
    .out_pc_wdata(out_pc_wdata), .out_exc(out_exc));

  always #5 clock = ~clock;

  typedef struct {
    logic mis; logic exc; logic wen; logic [4:0] rd;
    logic [31:0] npc; logic [31:0] wdata; logic [63:0] seq;
  } rec_t;

  int     n_cmp = 0, n_err = 0;
  rec_t   s1q[$], fq[$];
  logic   rst = 1'b1, last_acc;
  logic [63:0] seq_ctr = 64'h10;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural reference: what the op should do, from the ISA rules
  function automatic rec_t ref_op(input logic [7:0] op, input logic [31:0] addr, nxt, imm,
                                  input logic [4:0] rd, input logic [31:0] a, b,
                                  input logic [63:0] seq);
    rec_t r;
    logic legal, tk, jump;
    logic [31:0] tgt;
    legal = ($countones(op) == 1);
    tk = 1'b0;
    if (legal) begin
      if (op[0]) tk = (a == b);
      if (op[1]) tk = (a != b);
      if (op[2]) tk = ($signed(a) <  $signed(b));
      if (op[3]) tk = ($signed(a) >= $signed(b));
      if (op[4]) tk = (a <  b);
      if (op[5]) tk = (a >= b);
      if (op[6] || op[7]) tk = 1'b1;
    end
    tgt   = op[7] ? ((a + imm) & 32'hFFFF_FFFE) : (addr + imm);
    r.npc = tk ? tgt : addr + 32'd4;
    r.exc = 1'b0;
`ifdef RISCV_BRU_MISALIGN_EN
    r.exc = tk && (tgt % 4 != 0);
`endif
    r.mis   = legal && !r.exc && (r.npc != nxt);
    jump    = legal && (op[6] || op[7]);
    r.wen   = jump && (rd != 0) && !r.exc;
    r.wdata = jump ? addr + 32'd4 : 32'd0;
    r.rd    = rd;
    r.seq   = seq;
    return r;
  endfunction

  task automatic step(input logic v, input logic [7:0] op, input logic [31:0] addr, nxt, imm,
                      input logic [4:0] rd, input logic [31:0] a, b, input logic ordy);
    logic exp_rdy, pend;
    @(posedge clock);
    #1;
    reset = rst; in_vld = v; in_op = op; in_addr = addr; in_addr_next = nxt; in_immed = imm;
    in_rd = rd; rs1_data = a; rs2_data = b; in_seq = seq_ctr; out_rdy = ordy;
    @(negedge clock);
    pend    = !rst && (s1q.size() > 0) && s1q[0].mis;
    exp_rdy = !rst && !pend && (fq.size() + s1q.size() < 4);
    chk("in_rdy", in_rdy, exp_rdy);
    chk("flush", flush, pend);
    chk("flush_addr", flush_addr, pend ? s1q[0].npc : 32'd0);
    chk("flush_seq", flush_seq, pend ? s1q[0].seq + 64'd1 : 64'd0);
    chk("out_vld", out_vld, !rst && fq.size() > 0);
    if (!rst && fq.size() > 0) begin
      chk("out_wen", out_wen, fq[0].wen);
      chk("out_rd", out_rd, fq[0].rd);
      chk("out_wdata", out_wdata, fq[0].wdata);
      chk("out_seq", out_seq, fq[0].seq);
      chk("out_pc", out_pc_wdata, fq[0].npc);
      chk("out_exc", out_exc, fq[0].exc);
    end else begin
      chk("out_wdata_idle", out_wdata, 32'd0);
      chk("out_pc_idle", out_pc_wdata, 32'd0);
    end
    last_acc = v && exp_rdy;
    if (rst) begin
      s1q.delete(); fq.delete();
    end else begin
      if (ordy && fq.size() > 0) void'(fq.pop_front());
      if (s1q.size() > 0) fq.push_back(s1q.pop_front());
      if (last_acc) begin
        s1q.push_back(ref_op(op, addr, nxt, imm, rd, a, b, seq_ctr));
        seq_ctr++;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 8'h0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic rand_step();
    logic [7:0]  op;
    logic [31:0] addr, imm, a, b, nxt;
    logic [4:0]  rd;
    rec_t r;
    op   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
    addr = $urandom & 32'hFFFF_FFFC;
    imm  = 32'($signed(16'($urandom))) & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
    a    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    b    = ($urandom_range(0, 2) == 0) ? a : $urandom;
    rd   = 5'($urandom_range(0, 3));
    r    = ref_op(op, addr, 32'h0, imm, rd, a, b, 64'h0);
    case ($urandom_range(0, 3))
      0, 1: nxt = addr + 32'd4;
      2:    nxt = r.npc;
      default: nxt = $urandom;
    endcase
    step($urandom_range(0, 9) < 8, op, addr, nxt, imm, rd, a, b, $urandom_range(0, 9) < 7);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) idle();
    chk("rst_in_rdy", in_rdy, 1'b0);
    chk("rst_out_seq", out_seq, 64'd0);
    rst = 1'b0;
    idle();

    // BEQ taken, predicted not taken
    step(1'b1, 8'h01, 32'h100, 32'h104, 32'h20, 5'd3, 32'd5, 32'd5, 1'b1);
    idle();
    chk("beq_flush", flush, 1'b1);
    chk("beq_faddr", flush_addr, 32'h120);
    idle();
    chk("beq_pc", out_pc_wdata, 32'h120);
    chk("beq_wen", out_wen, 1'b0);

    // BLT signed taken; BLTU with same operands not taken
    step(1'b1, 8'h04, 32'h200, 32'h204, 32'h40, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    idle();
    chk("blt_flush", flush, 1'b1);
    chk("blt_faddr", flush_addr, 32'h240);
    step(1'b1, 8'h10, 32'h300, 32'h304, 32'h40, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    idle();
    chk("bltu_noflush", flush, 1'b0);

    // JALR target clears bit 0; rd=1 writes link, rd=0 does not
    step(1'b1, 8'h80, 32'h50, 32'h202, 32'h0, 5'd1, 32'h203, 32'h0, 1'b1);
    idle();
    chk("jalr_noflush", flush, 1'b0);
    idle();
    chk("jalr_wen", out_wen, 1'b1);
    chk("jalr_wdata", out_wdata, 32'h54);
    step(1'b1, 8'h80, 32'h50, 32'h202, 32'h0, 5'd0, 32'h203, 32'h0, 1'b1);
    idle();
    idle();
    chk("jalr_rd0_wen", out_wen, 1'b0);

    // Multi-hot op retires as an illegal no-op
    step(1'b1, 8'h03, 32'h400, 32'h999, 32'h10, 5'd2, 32'd7, 32'd7, 1'b1);
    idle();
    chk("illegal_noflush", flush, 1'b0);
    idle();
    chk("illegal_pc", out_pc_wdata, 32'h404);
    chk("illegal_wen", out_wen, 1'b0);

    // JAL to a misaligned target
    step(1'b1, 8'h40, 32'h0, 32'h4, 32'h6, 5'd1, 32'h0, 32'h0, 1'b1);
    idle();
`ifdef RISCV_BRU_MISALIGN_EN
    chk("mis_noflush", flush, 1'b0);
    idle();
    chk("mis_exc", out_exc, 1'b1);
    chk("mis_pc", out_pc_wdata, 32'h6);
`else
    chk("mis_flush", flush, 1'b1);
    chk("mis_faddr", flush_addr, 32'h6);
    idle();
    chk("mis_exc0", out_exc, 1'b0);
`endif
    repeat (2) idle();

    // Backpressure: credits stop acceptance at DEPTH, then all drain in order
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h01, 32'h1000 + 32'(n * 4), 32'h1004 + 32'(n * 4), 32'h80, 5'd0, 32'd1, 32'd2, 1'b0);
      if (last_acc) n++;
    end
    chk("bp_accepted", 64'(n), 64'd4);
    for (int i = 0; i < 12; i++) begin
      step(n < 6, 8'h01, 32'h1000 + 32'(n * 4), 32'h1004 + 32'(n * 4), 32'h80, 5'd0, 32'd1, 32'd2, 1'b1);
      if (last_acc) n++;
    end
    chk("bp_total", 64'(n), 64'd6);
    chk("bp_drained", 64'(fq.size() + s1q.size()), 64'd0);

    // Random traffic with a mid-run reset
    for (int i = 0; i < 800; i++) begin
      rst = (i >= 400 && i < 402);
      rand_step();
    end
    rst = 1'b0;
    repeat (10) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_exu_bru.md
Name: riscv_exu_bru

Overview:
- Parametrised branch/jump resolution unit in the EXU.
- Accepts decoded branch/jump ops over a valid/ready handshake and resolves all six conditional branches plus JAL/JALR.
- Generates a single-cycle redirect (flush) on misprediction and queues retire results in a DEPTH-entry FIFO toward writeback/RVFI.
- Two-stage pipeline: resolve register, then result FIFO with out_vld/out_rdy backpressure.

Parameters:
- XLEN, 32: data/address width.
- SEQ_W, 64: sequence-number width.
- DEPTH, 4: result FIFO entries; power of two, at least 2.

Ports:
- clock  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_vld  input  1  op valid
- in_rdy  output  1  unit can accept op
- in_op  input  8  one-hot: [0]BEQ [1]BNE [2]BLT [3]BGE [4]BLTU [5]BGEU [6]JAL [7]JALR
- in_addr  input  XLEN  op PC
- in_addr_next  input  XLEN  fetch-predicted next PC
- in_immed  input  XLEN  sign-extended immediate
- in_rd  input  5  destination register
- in_seq  input  SEQ_W  op sequence number
- rs1_data  input  XLEN  rs1 operand
- rs2_data  input  XLEN  rs2 operand
- flush  output  1  redirect pulse
- flush_addr  output  XLEN  redirect target
- flush_seq  output  SEQ_W  first sequence number on the new path
- out_vld  output  1  retire entry valid
- out_rdy  input  1  consumer takes entry
- out_wen  output  1  rd write enable
- out_rd  output  5  rd index
- out_wdata  output  XLEN  rd data
- out_seq  output  SEQ_W  op sequence number
- out_pc_wdata  output  XLEN  architectural next PC
- out_exc  output  1  exception flag (feature-dependent)

Behaviour:
- Reset: in_rdy=0 during reset. flush=0, out_vld=0, FIFO empty, stage-1 invalid. Data outputs are 0.
- Accept when in_vld && in_rdy.
- in_rdy = !reset && !flush && (FIFO count + stage-1 valid) < DEPTH. Credit-based, so no entry is ever dropped.
- Stage 1 (cycle N+1 after accept at N) computes the following.
  - Compares: BLT/BGE signed; BLTU/BGEU unsigned; all XLEN-wide.
  - Branch/JAL target = addr+immed. JALR target = (rs1+immed) & ~1. All arithmetic is mod 2^XLEN.
  - link = addr+4. npc = taken ? target : addr+4.
  - mispredict = (npc != addr_next).
  - JAL/JALR: out_wen = (rd != 0), wdata = link. Branches: out_wen = 0, wdata = 0.
  - in_op zero or multi-hot: illegal. Retire with out_wen=0 and no flush; npc = addr+4.
- Flush:
  - In cycle N+1, if mispredict: flush=1, flush_addr=npc, flush_seq=seq+1. Flush is exactly one cycle.
  - in_rdy=0 in the flush cycle, so the op presented that cycle is not accepted. Upstream presents corrected-path ops from N+2 onward.
- FIFO: stage-1 result enqueues at the end of cycle N+1. out_vld is asserted in N+2 at the earliest.
- Minimum accept-to-out_vld latency: 2 cycles.
- Entries leave in accept order. Pop when out_vld && out_rdy.
- Simultaneous push/pop when full is legal; the count is unchanged.
- Pointers wrap mod DEPTH.
- out_* are stable while out_vld && !out_rdy.
- Throughput: 1 op/cycle while no flush occurs and the FIFO is not full.
- Reset mid-operation: stage-1 and FIFO contents are discarded. Any pending flush is cancelled the same cycle.

Optional Feature:
- Macro: RISCV_BRU_MISALIGN_EN.
- Defined:
  - If taken && target[1:0] != 0, the entry retires with out_exc=1, out_wen=0, out_pc_wdata = the misaligned target.
  - No flush is raised; the trap handler owns the redirect.
- Undefined:
  - out_exc is tied 0.
  - Misaligned targets are treated as normal targets and flush if mispredicted.

Test Plan:
- BEQ addr=0x100, immed=0x20, rs1=rs2=5, addr_next=0x104 -> flush at N+1, flush_addr=0x120, flush_seq=seq+1; out entry pc_wdata=0x120, out_wen=0.
- BLT rs1=0xFFFFFFFF, rs2=1, BLTU same operands, both addr_next=addr+4 -> BLT taken with flush; BLTU not taken, no flush.
- JALR rs1=0x203, immed=0, rd=1, addr=0x50, addr_next=0x202 -> no flush; wdata=0x54, out_wen=1. Same op with rd=0 -> out_wen=0.
- Back-to-back 6 correct-prediction ops with out_rdy=0, DEPTH=4 -> in_rdy drops after 4 accepted. Raise out_rdy -> all 6 retire in order, none lost.
- in_op=0x03 (multi-hot) -> no flush, out_wen=0, pc_wdata=addr+4.
- With RISCV_BRU_MISALIGN_EN: JAL addr=0x0, immed=0x6 -> out_exc=1, no flush. Without the macro -> flush_addr=0x6.
